program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_INDEX, default 10: instruction_index of the first loaded halfword.
REQ-002 SHALL have parameter MAX_INSTR, default 256: largest accepted instruction count.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a load; sampled only in IDLE, DONE or ERROR.
REQ-006 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-007 SHALL have port byte_data  input  8  incoming program byte stream.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port download_program  output  1  holds the CPU in program-download mode.
REQ-010 SHALL have port program_write  output  1  one-cycle write strobe for the instruction memory.
REQ-011 SHALL have port instruction_index  output  32  halfword write address.
REQ-012 SHALL have port program_in  output  16  halfword write data.
REQ-013 SHALL have ports busy, done, error  output  1 each  loader status.

Function
REQ-014 SHALL accept a byte only on a rising edge where byte_valid and byte_ready are both 1.
REQ-015 SHALL implement states IDLE, LEN_LO, LEN_HI, INSTR_LO, INSTR_HI, CHECK, DONE, ERROR.
REQ-016 SHALL drive byte_ready 1 only in LEN_LO, LEN_HI, INSTR_LO, INSTR_HI and CHECK.
REQ-017 SHALL take start in IDLE/DONE/ERROR to LEN_LO, clearing done, error and the halfword counter n.
REQ-018 SHALL interpret the stream as: 16-bit count N (low byte first), then N halfwords, each low byte first.
REQ-019 SHALL go from LEN_HI to ERROR when N == 0 or N > MAX_INSTR; otherwise to INSTR_LO.
REQ-020 SHALL assert download_program from entering LEN_LO until leaving INSTR_HI (or CHECK) for DONE.
REQ-021 SHALL, on the cycle after accepting a high byte, set program_in = {high, low}, instruction_index = BASE_INDEX + n, and pulse program_write for exactly one cycle.
REQ-022 SHALL increment n after each write and go to DONE (or CHECK) after the N-th high byte, else to INSTR_LO.
REQ-023 SHALL hold program_in and instruction_index stable between writes.
REQ-024 SHALL tolerate any number of idle cycles (byte_valid 0) between bytes without changing outputs.
REQ-025 SHALL hold done 1 in DONE and error 1 in ERROR until the next start; busy = 1 in LEN_LO through CHECK.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL deassert download_program in ERROR, except for the checksum case in REQ-032.

Reset
REQ-028 SHALL, while reset is 1, immediately force: state IDLE, download_program 0, program_write 0, byte_ready 0, busy 0, done 0, error 0, program_in 0, instruction_index BASE_INDEX, n 0.
REQ-029 SHALL abort a load in progress on reset; no further program_write pulses until a new start.

Configuration
REQ-030 SHALL compile the checksum feature only when macro PROGRAM_LOADER_CHECKSUM_EN is defined.
REQ-031 SHALL, with the macro, enter CHECK after the N-th high byte and accept one byte that must equal the XOR of all 2N instruction bytes; match -> DONE.
REQ-032 SHALL, with the macro, on mismatch enter ERROR with download_program held 1 until the next start or reset.
REQ-033 SHALL, without the macro, have no CHECK state; INSTR_HI of the N-th halfword goes directly to DONE.

Verification
REQ-034 SHALL cover: reset, start, bytes 02 00 21 20 05 20 -> writes idx10=0x2021, idx11=0x2005; done=1, download_program=0.
REQ-035 SHALL cover: bytes 00 00 -> error=1, no program_write, download_program=0.
REQ-036 SHALL cover: bytes 01 01 (N=257, MAX_INSTR=256) -> ERROR after second byte, no writes.
REQ-037 SHALL cover: scenario REQ-034 with 3 idle cycles between each byte -> identical writes and values.
REQ-038 SHALL cover: reset asserted between low and high byte of halfword 2 -> all outputs at reset values at once, only idx10 written.
REQ-039 SHALL cover, with PROGRAM_LOADER_CHECKSUM_EN: REQ-034 stream + 0x24 -> done=1; + 0x25 -> error=1, download_program stays 1.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: 16-bit count N, then N halfwords (low byte first), written to
// instruction memory from BASE_INDEX. Define PROGRAM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module program_loader #(
    parameter int unsigned BASE_INDEX = 10,
    parameter int unsigned MAX_INSTR  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        download_program,
    output logic        program_write,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StInstrLo, StInstrHi, StCheck, StDone, StError
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StInstrLo, StInstrHi, StDone, StError
    } state_e;
`endif

    localparam logic [31:0] MaxInstrW  = 32'(MAX_INSTR);
    localparam logic [31:0] BaseIndexW = 32'(BASE_INDEX);

    state_e      state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] len_q, len_d;
    logic [15:0] n_q, n_d;
    logic        pw_q, pw_d;
    logic [15:0] pin_q, pin_d;
    logic [31:0] idx_q, idx_d;
    logic        accept;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  cks_q, cks_d;
    logic        fail_q, fail_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            lo_q    <= '0;
            len_q   <= '0;
            n_q     <= '0;
            pw_q    <= 1'b0;
            pin_q   <= '0;
            idx_q   <= BaseIndexW;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            cks_q   <= '0;
            fail_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            len_q   <= len_d;
            n_q     <= n_d;
            pw_q    <= pw_d;
            pin_q   <= pin_d;
            idx_q   <= idx_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            cks_q   <= cks_d;
            fail_q  <= fail_d;
`endif
        end
    end

    always_comb begin
        busy = 1'b0;
        case (state_q)
            StLenLo, StLenHi, StInstrLo, StInstrHi: busy = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StCheck:                                busy = 1'b1;
`endif
            default:                                busy = 1'b0;
        endcase
    end

    assign byte_ready        = busy;
    assign accept            = byte_valid & byte_ready;
    assign done              = (state_q == StDone);
    assign error             = (state_q == StError);
    assign program_write     = pw_q;
    assign program_in        = pin_q;
    assign instruction_index = idx_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // A checksum failure keeps the CPU parked in download mode until restarted.
    assign download_program  = busy | (error & fail_q);
`else
    assign download_program  = busy;
`endif

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        len_d   = len_q;
        n_d     = n_q;
        pw_d    = 1'b0;
        pin_d   = pin_q;
        idx_d   = idx_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        cks_d   = cks_q;
        fail_d  = fail_q;
`endif
        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StLenLo;
                    n_d     = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    cks_d   = '0;
                    fail_d  = 1'b0;
`endif
                end
            end
            StLenLo: begin
                if (accept) begin
                    lo_d    = byte_data;
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = {byte_data, lo_q};
                    if (len_d == '0 || {16'd0, len_d} > MaxInstrW) begin
                        state_d = StError;
                    end else begin
                        state_d = StInstrLo;
                    end
                end
            end
            StInstrLo: begin
                if (accept) begin
                    lo_d    = byte_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    cks_d   = cks_q ^ byte_data;
`endif
                    state_d = StInstrHi;
                end
            end
            StInstrHi: begin
                if (accept) begin
                    pw_d  = 1'b1;
                    pin_d = {byte_data, lo_q};
                    idx_d = BaseIndexW + {16'd0, n_q};
                    n_d   = n_q + 16'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    cks_d = cks_q ^ byte_data;
                    state_d = (n_d == len_q) ? StCheck : StInstrLo;
`else
                    state_d = (n_d == len_q) ? StDone : StInstrLo;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (accept) begin
                    if (byte_data == cks_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StError;
                        fail_d  = 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as stimulus is driven
// and popped by a monitor whenever program_write pulses.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, download_program, program_write, busy, done, error;
    logic [31:0] instruction_index;
    logic [15:0] program_in;

    int errors = 0;
    int checks = 0;
    int writes = 0;
    logic        prev_pw = 1'b0;
    logic [47:0] exp_q[$];

    program_loader #(.BASE_INDEX(10), .MAX_INSTR(256)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .byte_ready        (byte_ready),
        .download_program  (download_program),
        .program_write     (program_write),
        .instruction_index (instruction_index),
        .program_in        (program_in),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (program_write === 1'b1) begin
            writes++;
            check_eq("write_one_cycle", {47'd0, prev_pw}, 48'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", {instruction_index, program_in}, 48'd0);
            end else begin
                check_eq("write_idx_data", {instruction_index, program_in}, exp_q.pop_front());
            end
        end
        prev_pw = program_write;
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        k = 0;
        while (byte_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check_eq("byte_ready_timeout", 48'd0, 48'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_prog(input int gap, input logic [7:0] cks);
        logic [7:0] s [6];
        s = '{8'h02, 8'h00, 8'h21, 8'h20, 8'h05, 8'h20};
        exp_q.push_back({32'd10, 16'h2021});
        exp_q.push_back({32'd11, 16'h2005});
        for (int i = 0; i < 6; i++) send_byte(s[i], gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(cks, gap);
`else
        if (cks == 8'h00) check_eq("unused_cks_arg", {40'd0, cks}, 48'd0);
`endif
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done === 1'b1 || error === 1'b1) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) check_eq("end_timeout", 48'd0, 48'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w0;
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #12;
        check_eq("reset_flags", {busy, done, error, download_program, program_write, byte_ready},
                 48'd0);
        check_eq("reset_idx_pin", {instruction_index, program_in}, {32'd10, 16'd0});
        @(negedge clk) reset = 1'b0;

        // Nominal load, with a start pulse mid-load that must be ignored.
        do_start();
        check_eq("start_busy_dl_ready", {45'd0, busy, download_program, byte_ready}, 48'd7);
        exp_q.push_back({32'd10, 16'h2021});
        exp_q.push_back({32'd11, 16'h2005});
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        do_start();
        send_byte(8'h21, 0);
        send_byte(8'h20, 0);
        send_byte(8'h05, 0);
        send_byte(8'h20, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h24, 0);
`endif
        wait_end();
        check_eq("nominal_done_err_dl", {45'd0, done, error, download_program}, 48'd4);
        check_eq("nominal_queue_empty", 48'(exp_q.size()), 48'd0);
        check_eq("nominal_outputs_hold", {instruction_index, program_in}, {32'd11, 16'h2005});

        // Zero length
        w0 = writes;
        do_start();
        check_eq("restart_clears_done", {47'd0, done}, 48'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_end();
        check_eq("zero_len_flags", {45'd0, done, error, download_program}, 48'd2);
        check_eq("zero_len_no_write", 48'(writes), 48'(w0));

        // N = 257 exceeds MAX_INSTR
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        check_eq("too_long_error", {45'd0, done, error, download_program}, 48'd2);
        repeat (3) @(negedge clk);
        check_eq("too_long_no_write", 48'(writes), 48'(w0));

        // Same program with idle gaps between bytes
        do_start();
        send_prog(3, 8'h24);
        wait_end();
        check_eq("gap_done_err_dl", {45'd0, done, error, download_program}, 48'd4);
        check_eq("gap_queue_empty", 48'(exp_q.size()), 48'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        do_start();
        send_prog(0, 8'h25);
        wait_end();
        check_eq("cks_bad_flags", {45'd0, done, error, download_program}, 48'd3);
        check_eq("cks_bad_queue_empty", 48'(exp_q.size()), 48'd0);
`endif

        // Reset between low and high byte of halfword 2
        w0 = writes;
        do_start();
        exp_q.push_back({32'd10, 16'h2021});
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h21, 0);
        send_byte(8'h20, 0);
        send_byte(8'h05, 0);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_flags", {busy, done, error, download_program, program_write, byte_ready},
                 48'd0);
        check_eq("abort_idx_pin", {instruction_index, program_in}, {32'd10, 16'd0});
        @(negedge clk) reset = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h20;
        repeat (8) @(negedge clk);
        byte_valid = 1'b0;
        check_eq("abort_one_write", 48'(writes), 48'(w0 + 1));
        check_eq("abort_queue_empty", 48'(exp_q.size()), 48'd0);
        check_eq("abort_idle", {46'd0, busy, download_program}, 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
